chip_6502_bus_adapter: RTL
==========================

// Module: chip_6502_bus_adapter
// PURPOSE
//  Synchronous bridge between a 6502 core's external bus and a req/ack memory port.
//  Stalls the CPU via cpu_rdy while memory responds, with an optional ack timeout.
//  Aggregates NUM_IRQ interrupt sources into irq_n/nmi_n.
//  Records opcode-fetch addresses in a trace FIFO for debug.
// PARAMETERS
//  ADDR_W      16   CPU/memory address width
//  DATA_W      8    data width
//  NUM_IRQ     4    interrupt source channels (1..32)
//  NMI_MASK    0    NUM_IRQ-bit mask; set bits route the channel to nmi_n, not irq_n
//  TIMEOUT     255  BUSY cycles before abort; 0 = never abort
//  TRACE_DEPTH 16   trace FIFO entries, power of two >= 2
// PORTS
//  phi          in   1        clock; all state updates on rising edge
//  res          in   1        asynchronous active-high reset
//  cpu_valid    in   1        CPU presents a bus cycle (sampled only when cpu_rdy=1)
//  cpu_ab       in   ADDR_W   CPU address
//  cpu_rw       in   1        1=read, 0=write
//  cpu_sync     in   1        opcode-fetch cycle marker
//  cpu_db_i     in   DATA_W   write data from CPU
//  cpu_db_o     out  DATA_W   read data to CPU, valid while cpu_done=1 and after
//  cpu_rdy      out  1        adapter idle, will accept a cycle
//  cpu_done     out  1        one-cycle pulse: cycle complete
//  mem_req      out  1        memory request, held until mem_ack or abort
//  mem_we       out  1        1=write
//  mem_addr     out  ADDR_W   latched address
//  mem_wdata    out  DATA_W   latched write data
//  mem_rdata    in   DATA_W   read data, valid with mem_ack
//  mem_ack      in   1        single-cycle acknowledge
//  bus_err      out  1        sticky: a timeout abort occurred
//  irq_src      in   NUM_IRQ  level sources, rising-edge detected
//  irq_en       in   NUM_IRQ  per-channel enable (irq_n path only)
//  irq_clr      in   NUM_IRQ  write-1-to-clear pending
//  irq_pending  out  NUM_IRQ  latched pending bits
//  irq_n, nmi_n out  1        active-low interrupt lines to CPU
//  trace_addr   out  ADDR_W   FIFO head (show-ahead)
//  trace_valid  out  1        FIFO non-empty
//  trace_pop    in   1        consume head when trace_valid=1
//  trace_ovf    out  1        sticky: push dropped because FIFO was full
// BEHAVIOUR
//  Reset (async): state IDLE, cpu_rdy=1, irq_n=nmi_n=1, FIFO empty, all other outputs 0.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: cpu_rdy=1. cpu_valid=1 at edge N latches ab/rw/db_i into mem_*; after N:
//    mem_req=1, cpu_rdy=0, state BUSY.
//  - BUSY: mem_* held stable.
//    - mem_ack at edge M: reads capture mem_rdata into cpu_db_o; mem_req=0; state DONE.
//    - No ack after TIMEOUT BUSY cycles (TIMEOUT!=0): mem_req=0, cpu_db_o all-ones,
//      bus_err=1, state DONE.
//    - mem_ack outside BUSY is ignored.
//  - DONE: cpu_done=1 for exactly one cycle, cpu_rdy=0; next state IDLE.
//    Minimum: 3 cycles per access.
//  - Writes leave cpu_db_o unchanged.
//  - res mid-BUSY drops mem_req immediately; the memory side tolerates abandoned requests.
//  Trace FIFO: push {cpu_ab} when a cycle is accepted in IDLE with cpu_sync=1 and cpu_rw=1.
//  - Full and push without pop: drop the entry, set trace_ovf. Only res clears trace_ovf.
//  - Full with simultaneous push and pop: both occur, no overflow.
//  - Pop when empty is ignored. Pointers wrap modulo TRACE_DEPTH.
//  IRQ: src_q registers irq_src; rise = irq_src & ~src_q.
//  - pending <= (pending & ~irq_clr) | rise; set wins over clear in the same cycle.
//  - Registered outputs, one cycle after pending changes:
//    irq_n = ~|(pending & irq_en & ~NMI_MASK); nmi_n = ~|(pending & NMI_MASK).
//  - irq_en does not gate NMI channels.
// TESTING
//  1 Read, ack 2 cycles after req: ab=16'hFFFC, mem_rdata=8'h34 -> mem_req high 2 cycles,
//    cpu_done pulse, cpu_db_o=8'h34, cpu_rdy back to 1 the next cycle.
//  2 Write, ab=16'h0200, db_i=8'hA5, ack 1 cycle after req -> mem_we=1, mem_wdata=8'hA5,
//    cpu_db_o unchanged.
//  3 TIMEOUT=4, no ack -> mem_req drops after 4 BUSY cycles, cpu_db_o=8'hFF, bus_err=1;
//    a following acked access still completes normally.
//  4 TRACE_DEPTH=4: 5 opcode fetches, no pop -> trace_ovf=1;
//    pops yield the first 4 addresses in order; full push+pop same cycle sets no overflow.
//  5 NMI_MASK=4'b0010, irq_en=4'b0001: pulse irq_src[0] -> irq_n=0; pulse irq_src[1] -> nmi_n=0;
//    irq_clr[0] same cycle as a new rise on irq_src[0] -> pending[0] stays 1.
//  6 Assert res while BUSY -> mem_req=0 and cpu_rdy=1 without a clock edge; irq_n=1, FIFO empty.

Source files
------------

// File: rtl/chip_6502_bus_adapter.sv
// rtl/chip_6502_bus_adapter.sv - 6502 external bus to req/ack memory bridge with IRQ aggregation and fetch trace
//
// Purpose:
//   Bridges a 6502 core's bus cycles onto a request/acknowledge memory port,
//   stalling the CPU through cpu_rdy until memory answers or an optional ack
//   timeout expires. Folds NUM_IRQ edge-detected sources into irq_n/nmi_n and
//   keeps a small FIFO of opcode-fetch addresses for debug.
//
// Ports:
//   phi, res                       clock (rising edge), asynchronous active-high reset
//   cpu_valid/ab/rw/sync/db_i      CPU bus cycle request (sampled only while cpu_rdy=1)
//   cpu_db_o, cpu_rdy, cpu_done    read data, idle/accept flag, one-cycle completion pulse
//   mem_req/we/addr/wdata          latched memory request, held until ack or abort
//   mem_rdata, mem_ack             memory read data and single-cycle acknowledge
//   bus_err                        sticky timeout-abort flag
//   irq_src/en/clr, irq_pending    interrupt sources, enables, W1C clear, pending bits
//   irq_n, nmi_n                   active-low interrupt lines to the CPU
//   trace_addr/valid/pop/ovf       show-ahead fetch-trace FIFO and sticky overflow

module chip_6502_bus_adapter #(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 8,
  parameter int                 NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] NMI_MASK    = '0,
  parameter int                 TIMEOUT     = 255,
  parameter int                 TRACE_DEPTH = 16
) (
  input  logic               phi,
  input  logic               res,
  input  logic               cpu_valid,
  input  logic [ADDR_W-1:0]  cpu_ab,
  input  logic               cpu_rw,
  input  logic               cpu_sync,
  input  logic [DATA_W-1:0]  cpu_db_i,
  output logic [DATA_W-1:0]  cpu_db_o,
  output logic               cpu_rdy,
  output logic               cpu_done,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               bus_err,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] irq_clr,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_n,
  output logic               nmi_n,
  output logic [ADDR_W-1:0]  trace_addr,
  output logic               trace_valid,
  input  logic               trace_pop,
  output logic               trace_ovf
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam int            PW   = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          accept;
  logic          complete;
  logic          abort;
  logic          timeout_hit;
  logic [TW-1:0] tcnt;

  // ---------------------------------------------------------------------------
  // Bus cycle FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge phi or posedge res) begin
    if (res) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_valid) begin
          accept   = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An ack arriving on the very cycle the timer expires still wins.
        if (mem_ack) begin
          complete = 1'b1;
          state_nx = ST_DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Decoded straight from state so that reset raises cpu_rdy without a clock.
  assign cpu_rdy  = (state == ST_IDLE);
  assign cpu_done = (state == ST_DONE);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (tcnt == TLIM);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Memory port and CPU read-data datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge phi or posedge res) begin
    if (res) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_db_o  <= '0;
      bus_err   <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= ~cpu_rw;
        mem_addr  <= cpu_ab;
        mem_wdata <= cpu_db_i;
        tcnt      <= '0;
      end
      if (complete) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          cpu_db_o <= mem_rdata;
        end
      end else if (abort) begin
        mem_req  <= 1'b0;
        cpu_db_o <= '1;
        bus_err  <= 1'b1;
      end else if (state == ST_BUSY) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Opcode-fetch trace FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] tmem [TRACE_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       tcount;
  logic              t_push_req;
  logic              t_push;
  logic              t_pop;
  logic              t_full;

  assign t_push_req  = accept & cpu_sync & cpu_rw;
  assign trace_valid = (tcount != '0);
  assign t_full      = (tcount == (PW+1)'(TRACE_DEPTH));
  assign t_pop       = trace_pop & trace_valid;
  // A pop in the same cycle frees the slot the push needs.
  assign t_push      = t_push_req & (~t_full | t_pop);
  assign trace_addr  = tmem[rd_ptr];

  always_ff @(posedge phi) begin
    if (t_push) begin
      tmem[wr_ptr] <= cpu_ab;
    end
  end

  always_ff @(posedge phi or posedge res) begin
    if (res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tcount    <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (t_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (t_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({t_push, t_pop})
        2'b10:   tcount <= tcount + (PW+1)'(1);
        2'b01:   tcount <= tcount - (PW+1)'(1);
        default: tcount <= tcount;
      endcase
      if (t_push_req && !t_push) begin
        trace_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt aggregation
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] rise;

  assign rise = irq_src & ~src_q;

  always_ff @(posedge phi or posedge res) begin
    if (res) begin
      src_q       <= '0;
      irq_pending <= '0;
      irq_n       <= 1'b1;
      nmi_n       <= 1'b1;
    end else begin
      src_q       <= irq_src;
      // A new edge beats a simultaneous clear so no event is lost.
      irq_pending <= (irq_pending & ~irq_clr) | rise;
      irq_n       <= ~|(irq_pending & irq_en & ~NMI_MASK);
      nmi_n       <= ~|(irq_pending & NMI_MASK);
    end
  end

endmodule
